mul_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It implements MIPS MULT, MULTU, DIV and DIVU alongside the combinational ALU. The control path issues an operation with a single-cycle `start` and stalls on `busy`, then reads `hi` and `lo`. The unit processes one result bit per cycle, which trades latency for a small area.

---
 rtl/mul_div_unit_pkg.sv | 27 ++
 rtl/mul_div_unit_if.sv | 32 +++
 rtl/ConditionalNegate.sv | 13 +
 rtl/mul_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes,
// FSM state encodings and small opcode decode helpers.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Opcode bit 1 selects divide, bit 0 selects the unsigned variant.
  function automatic logic is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the control path (master) and the
// multiply/divide unit (slave).
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic                  start;
  md_op_e                op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  hiWrite;
  logic                  loWrite;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  divByZero;

  modport master (
    output start, op, a, b, hiWrite, loWrite, writeData,
    input  busy, done, hi, lo, divByZero
  );

  modport slave (
    input  start, op, a, b, hiWrite, loWrite, writeData,
    output busy, done, hi, lo, divByZero
  );

endinterface

// File: rtl/ConditionalNegate.sv
// Two's-complement conditional negation, used for operand magnitudes and
// for the final sign correction of product, quotient and remainder.
module ConditionalNegate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO: one result bit per cycle,
// shift-add multiply and restoring divide on operand magnitudes.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  mul_div_unit_if.slave   bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  md_state_e      state_q, state_d;
  md_op_e         op_q, op_d;
  logic           sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  // Operand magnitudes are taken at issue so the iteration is sign-agnostic.
  logic         in_sign_a, in_sign_b;
  logic [W-1:0] mag_a, mag_b;

  assign in_sign_a = is_signed_op(bus.op) & bus.a[W-1];
  assign in_sign_b = is_signed_op(bus.op) & bus.b[W-1];

  ConditionalNegate #(.WIDTH(W)) u_neg_a (.in(bus.a), .neg(in_sign_a), .out(mag_a));
  ConditionalNegate #(.WIDTH(W)) u_neg_b (.in(bus.b), .neg(in_sign_b), .out(mag_b));

  logic [W:0]   mul_sum;
  logic [W:0]   div_sh;
  logic [W-1:0] div_diff;
  logic         div_ge;

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? a_q : '0)};
  assign div_sh   = {rem_q, acc_q[W-1]};
  assign div_ge   = div_sh >= {1'b0, b_q};
  assign div_diff = div_sh[W-1:0] - b_q;

  logic           neg_prod, neg_quot, neg_rem, div_zero;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  assign neg_prod = (op_q == MD_MULT) & (sign_a_q ^ sign_b_q);
  assign neg_quot = (op_q == MD_DIV) & (sign_a_q ^ sign_b_q);
  assign neg_rem  = (op_q == MD_DIV) & sign_a_q;
  assign div_zero = (b_q == '0);

  ConditionalNegate #(.WIDTH(2*W)) u_neg_prod (.in(acc_q), .neg(neg_prod), .out(prod_fix));
  ConditionalNegate #(.WIDTH(W)) u_neg_quot (.in(acc_q[W-1:0]), .neg(neg_quot), .out(quot_fix));
  ConditionalNegate #(.WIDTH(W)) u_neg_rem (.in(rem_q), .neg(neg_rem), .out(rem_fix));

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    case (state_q)
      MD_IDLE: begin
        if (bus.start) begin
          state_d  = MD_RUN;
          busy_d   = 1'b1;
          op_d     = bus.op;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          a_d      = mag_a;
          b_d      = mag_b;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          rem_d    = '0;
          acc_d    = is_div(bus.op) ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
        end else begin
          if (bus.hiWrite) hi_d = bus.writeData;
          if (bus.loWrite) lo_d = bus.writeData;
        end
      end

      MD_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div(op_q)) begin
          rem_d = div_ge ? div_diff : div_sh[W-1:0];
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        if (cnt_q == CW'(W - 1)) state_d = MD_FIX;
      end

      MD_FIX: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div(op_q)) begin
          // With a zero divisor the remainder path already reproduces a.
          lo_d  = div_zero ? '1 : quot_fix;
          hi_d  = rem_fix;
          dbz_d = div_zero;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end

      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.divByZero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (W=32): latency, results,
// divide-by-zero, MTHI/MTLO arbitration and reset abort.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [W-1:0] old_hi, old_lo;

  always #5 clk = ~clk;

  mul_div_unit_if #(.DATA_WIDTH(W)) bus ();

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.hiWrite   = 1'b0;
    bus.loWrite   = 1'b0;
    bus.writeData = '0;
  endtask

  task automatic issue(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit with_hi_write);
    @(negedge clk);
    old_hi    = bus.hi;
    old_lo    = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (with_hi_write) begin
      bus.hiWrite   = 1'b1;
      bus.writeData = 32'hDEADBEEF;
    end
  endtask

  // Issues one op, tracks busy/done per cycle and checks the result in the done cycle.
  task automatic run_op(input string name, input md_op_e op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dbz,
                        input bit with_hi_write, input bit disturb);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    issue(op, a, b, with_hi_write);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      idle_inputs();
      if (disturb && i == 5) begin
        bus.start     = 1'b1;
        bus.op        = MD_MULTU;
        bus.a         = 32'd9;
        bus.b         = 32'd9;
        bus.loWrite   = 1'b1;
        bus.writeData = 32'h11111111;
      end
      if (bus.busy) busy_cnt++;
      if (i == W + 1) begin
        check({name, " hold_hi"}, bus.hi, old_hi);
        check({name, " hold_lo"}, bus.lo, old_lo);
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({name, " latency"}, lat, W + 2);
    check({name, " busy_cycles"}, busy_cnt, W + 1);
    check({name, " busy_at_done"}, bus.busy, 1'b0);
    check({name, " hi"}, bus.hi, exp_hi);
    check({name, " lo"}, bus.lo, exp_lo);
    check({name, " dbz"}, bus.divByZero, exp_dbz);
    @(negedge clk);
    check({name, " done_pulse"}, bus.done, 1'b0);
    check({name, " dbz_held"}, bus.divByZero, exp_dbz);
  endtask

  initial begin
    int done_seen;
    idle_inputs();
    bus.op = MD_MULT;
    bus.a  = '0;
    bus.b  = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst hi", bus.hi, 0);
    check("rst lo", bus.lo, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst dbz", bus.divByZero, 0);
    rst = 1'b0;

    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0);
    run_op("mult_neg", MD_MULT, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 0, 0);
    run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 0);
    run_op("divu_zero", MD_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 0, 0);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 0, 0);
    run_op("div_zero_neg", MD_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 0, 0);

    // MTHI alone, then MTHI and MTLO together.
    @(negedge clk);
    bus.hiWrite   = 1'b1;
    bus.writeData = 32'hA5A5A5A5;
    @(negedge clk);
    idle_inputs();
    check("mthi hi", bus.hi, 32'hA5A5A5A5);
    check("mthi lo", bus.lo, 32'hFFFFFFFF);
    bus.hiWrite   = 1'b1;
    bus.loWrite   = 1'b1;
    bus.writeData = 32'h13579BDF;
    @(negedge clk);
    idle_inputs();
    check("mthilo hi", bus.hi, 32'h13579BDF);
    check("mthilo lo", bus.lo, 32'h13579BDF);

    // Reset in the middle of a MULT aborts it without a done pulse.
    issue(MD_MULT, 32'hFFFFFFF9, 32'd6, 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      idle_inputs();
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", bus.busy, 0);
    check("abort hi", bus.hi, 0);
    check("abort lo", bus.lo, 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort no_done", done_seen, 0);

    // Fresh op after reset; start+hiWrite drops the write, busy-time start/loWrite ignored.
    @(negedge clk);
    bus.hiWrite   = 1'b1;
    bus.writeData = 32'h0BADF00D;
    @(negedge clk);
    idle_inputs();
    check("pre_arb hi", bus.hi, 32'h0BADF00D);
    run_op("arb", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
